// File: rtl/match_result_streamer.sv
// Unloads the four matched-result banks onto the 16-bit result stream:
// a header word with the row count, then 12 words per row (bank 0..3, 3 parts each).
module match_result_streamer #(
  parameter int ENTRY_W = 47,
  parameter int ADDR_W  = 9,
  parameter int OUT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [9:0]         match_count,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [ENTRY_W-1:0] bank_dout_0,
  input  logic [ENTRY_W-1:0] bank_dout_1,
  input  logic [ENTRY_W-1:0] bank_dout_2,
  input  logic [ENTRY_W-1:0] bank_dout_3,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  state_t                   state;
  logic [9:0]               cnt;
  logic [9:0]               row;
  logic [3:0]               w;
  logic [4*ENTRY_W-1:0]     hold;
  logic [ENTRY_W-1:0]       sel_entry;
  logic [OUT_W-1:0]         hold_word;
  logic [OUT_W-1:0]         first_word;

  // Word index decoded into bank (w/3) and part (w%3) without a divider.
  always_comb begin
    sel_entry = hold[ENTRY_W-1:0];
    case (w)
      4'd3, 4'd4, 4'd5:   sel_entry = hold[2*ENTRY_W-1:ENTRY_W];
      4'd6, 4'd7, 4'd8:   sel_entry = hold[3*ENTRY_W-1:2*ENTRY_W];
      4'd9, 4'd10, 4'd11: sel_entry = hold[4*ENTRY_W-1:3*ENTRY_W];
      default:            sel_entry = hold[ENTRY_W-1:0];
    endcase
    hold_word = sel_entry[15:0];
    case (w)
      4'd0, 4'd3, 4'd6, 4'd9:  hold_word = OUT_W'(sel_entry[ENTRY_W-1:32]);
      4'd1, 4'd4, 4'd7, 4'd10: hold_word = sel_entry[31:16];
      default:                 hold_word = sel_entry[15:0];
    endcase
    first_word = OUT_W'(bank_dout_0[ENTRY_W-1:32]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      row       <= '0;
      w         <= '0;
      hold      <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= (match_count > 10'd512) ? 10'd512 : match_count;
            row     <= '0;
            w       <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= PRIME;
          end
        end
        PRIME: begin
          out_valid <= 1'b1;
          out_data  <= {{(OUT_W-10){1'b0}}, cnt};
          state     <= STREAM;
        end
        STREAM: begin
          if (row == cnt) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            out_valid <= 1'b1;
            if (w == 4'd0) begin
              // Word 0 bypasses the hold register so the next row's address can be issued now.
              out_data <= first_word;
              hold     <= {bank_dout_3, bank_dout_2, bank_dout_1, bank_dout_0};
              if (row != cnt - 10'd1)
                rd_addr <= rd_addr + 1'b1;
            end else begin
              out_data <= hold_word;
            end
            if (w == 4'd11) begin
              w   <= '0;
              row <= row + 10'd1;
            end else begin
              w <= w + 4'd1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
